// File: rtl/process_scheduler.sv
// rtl/process_scheduler.sv - step/grant sequencer for generated chip processes
//
// Runs one init step, then grants PROCESSES slots one at a time, in ascending
// order, within each step. A print strobe closes every step. The run ends
// when any process raises its stop flag or when MAX_STEPS steps have completed.
//
// Ports:
//   clock_i               system clock, rising edge
//   reset_i               synchronous, active-high reset
//   start_i               begins a run from IDLE or DONE
//   process_stop_i        per-process stop flag (bit i = process i)
//   process_return_code_i per-process return code, process i at [i*RC_WIDTH +: RC_WIDTH]
//   init_o                one-cycle init pulse (step = -1)
//   process_enable_o      one-hot grant
//   process_current_o     index of the granted process
//   step_o                signed current step
//   print_o               one-cycle end-of-step strobe
//   running_o             high from INIT through the last CHECK
//   done_o                high in DONE
//   finish_code_o         0 = stopped, 1 = timeout
//   return_code_o         rc of the lowest-index stopped process, 0 on timeout
module process_scheduler #(
    parameter int PROCESSES  = 4,
    parameter int MAX_STEPS  = 100,
    parameter int STEP_WIDTH = 32,
    parameter int RC_WIDTH   = 8
) (
    input  logic                            clock_i,
    input  logic                            reset_i,
    input  logic                            start_i,
    input  logic [PROCESSES-1:0]            process_stop_i,
    input  logic [PROCESSES*RC_WIDTH-1:0]   process_return_code_i,
    output logic                            init_o,
    output logic [PROCESSES-1:0]            process_enable_o,
    output logic [3:0]                      process_current_o,
    output logic signed [STEP_WIDTH-1:0]    step_o,
    output logic                            print_o,
    output logic                            running_o,
    output logic                            done_o,
    output logic                            finish_code_o,
    output logic [RC_WIDTH-1:0]             return_code_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [3:0]                   LAST_SLOT = 4'(PROCESSES - 1);
    localparam logic [PROCESSES-1:0]         EN_ONE    = PROCESSES'(1);
    localparam logic signed [STEP_WIDTH-1:0] STEP_ONE  = STEP_WIDTH'(1);
    localparam logic signed [STEP_WIDTH-1:0] STEP_MAX  = STEP_WIDTH'(MAX_STEPS);
    localparam bit                           NO_STEPS  = (MAX_STEPS == 0);

    state_t                         state_q, state_d;
    logic [3:0]                     slot_q, slot_d;
    logic signed [STEP_WIDTH-1:0]   step_q, step_d;
    logic                           init_q, init_d;
    logic [PROCESSES-1:0]           enable_q, enable_d;
    logic [3:0]                     current_q, current_d;
    logic                           print_q, print_d;
    logic                           running_q, running_d;
    logic                           done_q, done_d;
    logic                           finish_q, finish_d;
    logic [RC_WIDTH-1:0]            rc_q, rc_d;

    logic                           stop_any;
    logic [RC_WIDTH-1:0]            stop_rc;

    // Descending scan so the lowest-index stopped process wins.
    always_comb begin
        stop_any = |process_stop_i;
        stop_rc  = '0;
        for (int i = PROCESSES - 1; i >= 0; i--) begin
            if (process_stop_i[i]) begin
                stop_rc = process_return_code_i[i*RC_WIDTH +: RC_WIDTH];
            end
        end
    end

    // Outputs are computed for the state being entered, so every output is
    // a plain register aligned with state_q.
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        step_d    = step_q;
        init_d    = 1'b0;
        enable_d  = '0;
        current_d = 4'd0;
        print_d   = 1'b0;
        running_d = running_q;
        done_d    = done_q;
        finish_d  = finish_q;
        rc_d      = rc_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d   = S_INIT;
                    init_d    = 1'b1;
                    step_d    = '1;
                    slot_d    = 4'd0;
                    running_d = 1'b1;
                    done_d    = 1'b0;
                    finish_d  = 1'b0;
                    rc_d      = '0;
                end
            end
            S_INIT: begin
                if (NO_STEPS) begin
                    state_d   = S_DONE;
                    step_d    = '0;
                    running_d = 1'b0;
                    done_d    = 1'b1;
                    finish_d  = 1'b1;
                    rc_d      = '0;
                end else begin
                    state_d   = S_RUN;
                    step_d    = '0;
                    slot_d    = 4'd0;
                    enable_d  = EN_ONE;
                    current_d = 4'd0;
                end
            end
            S_RUN: begin
                if (slot_q == LAST_SLOT) begin
                    state_d = S_CHECK;
                    print_d = 1'b1;
                end else begin
                    slot_d    = slot_q + 4'd1;
                    enable_d  = EN_ONE << (slot_q + 4'd1);
                    current_d = slot_q + 4'd1;
                end
            end
            S_CHECK: begin
                // Stop is checked first: it wins over a coincident timeout.
                if (stop_any) begin
                    state_d   = S_DONE;
                    running_d = 1'b0;
                    done_d    = 1'b1;
                    finish_d  = 1'b0;
                    rc_d      = stop_rc;
                end else if (step_q + STEP_ONE >= STEP_MAX) begin
                    state_d   = S_DONE;
                    step_d    = STEP_MAX;
                    running_d = 1'b0;
                    done_d    = 1'b1;
                    finish_d  = 1'b1;
                    rc_d      = '0;
                end else begin
                    state_d   = S_RUN;
                    step_d    = step_q + STEP_ONE;
                    slot_d    = 4'd0;
                    enable_d  = EN_ONE;
                    current_d = 4'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            slot_q    <= 4'd0;
            step_q    <= '0;
            init_q    <= 1'b0;
            enable_q  <= '0;
            current_q <= 4'd0;
            print_q   <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            finish_q  <= 1'b0;
            rc_q      <= '0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            step_q    <= step_d;
            init_q    <= init_d;
            enable_q  <= enable_d;
            current_q <= current_d;
            print_q   <= print_d;
            running_q <= running_d;
            done_q    <= done_d;
            finish_q  <= finish_d;
            rc_q      <= rc_d;
        end
    end

    assign init_o            = init_q;
    assign process_enable_o  = enable_q;
    assign process_current_o = current_q;
    assign step_o            = step_q;
    assign print_o           = print_q;
    assign running_o         = running_q;
    assign done_o            = done_q;
    assign finish_code_o     = finish_q;
    assign return_code_o     = rc_q;

endmodule
